// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M/RV64M execution unit for the EX stage.
// Handles MUL/MULH/MULHSU/MULHU through a short product pipeline and
// DIV/DIVU/REM/REMU through an iterative restoring radix-2 divider.
// One operation in flight; requests arriving while busy are ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             abort any in-flight operation (no response produced)
//   req_valid         request present (only sampled when idle)
//   req_opcode        funct3 of the M-extension instruction
//   req_op1, req_op2  forwarded rs1 / rs2 values
//   busy              unit is not idle
//   resp_valid        one-cycle result pulse
//   resp_data         result, held until the next resp_valid
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pipeline depth is MUL_LAT-1; keep at least one array entry so MUL_LAT=1 elaborates.
  localparam int PIPE_N = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int MUL_LAST_I = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int DIV_LAST_I = XLEN - 1;
  localparam logic [5:0] MUL_LAST = MUL_LAST_I[5:0];
  localparam logic [5:0] DIV_LAST = DIV_LAST_I[5:0];

  state_t          state_r, state_nx_s;
  logic [5:0]      cnt_r;
  logic            op_rem_r, neg_q_r, neg_r_r;
  logic [XLEN-1:0] div_quo_r, div_rem_r, div_dvs_r;
  logic [XLEN-1:0] mul_pipe_r [PIPE_N];
  logic            busy_r, resp_valid_r;
  logic [XLEN-1:0] resp_data_r;

  // Request decode
  logic            is_div_s, div_signed_s, op1_neg_s, op2_neg_s;
  logic            div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0] op1_mag_s, op2_mag_s, special_res_s;
  logic            mul_sx1_s, mul_sx2_s;
  logic [2*XLEN-1:0] mul_a_s, mul_b_s, mul_prod_s;
  logic [XLEN-1:0] mul_sel_s;

  // Divider step
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic            q_bit_s;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s, div_res_s;

  assign is_div_s     = req_opcode[2];
  assign div_signed_s = ~req_opcode[0];   // DIV=4, REM=6 are the signed forms
  assign op1_neg_s    = div_signed_s & req_op1[XLEN-1];
  assign op2_neg_s    = div_signed_s & req_op2[XLEN-1];
  assign op1_mag_s    = op1_neg_s ? (~req_op1 + {{(XLEN-1){1'b0}}, 1'b1}) : req_op1;
  assign op2_mag_s    = op2_neg_s ? (~req_op2 + {{(XLEN-1){1'b0}}, 1'b1}) : req_op2;
  assign div_zero_s   = (req_op2 == {XLEN{1'b0}});
  assign div_ovf_s    = div_signed_s & (req_op1 == {1'b1, {(XLEN-1){1'b0}}})
                        & (req_op2 == {XLEN{1'b1}});
  assign special_s    = div_zero_s | div_ovf_s;

  // Divide-by-zero dominates; otherwise the only other special is signed overflow.
  assign special_res_s = div_zero_s ? (req_opcode[1] ? req_op1 : {XLEN{1'b1}})
                                    : (req_opcode[1] ? {XLEN{1'b0}} : req_op1);

  // MULH (1) and MULHSU (2) sign-extend op1; only MULH sign-extends op2.
  assign mul_sx1_s  = (req_opcode[1:0] == 2'd1) | (req_opcode[1:0] == 2'd2);
  assign mul_sx2_s  = (req_opcode[1:0] == 2'd1);
  assign mul_a_s    = {{XLEN{mul_sx1_s & req_op1[XLEN-1]}}, req_op1};
  assign mul_b_s    = {{XLEN{mul_sx2_s & req_op2[XLEN-1]}}, req_op2};
  assign mul_prod_s = mul_a_s * mul_b_s;
  assign mul_sel_s  = (req_opcode[1:0] == 2'd0) ? mul_prod_s[XLEN-1:0]
                                                : mul_prod_s[2*XLEN-1:XLEN];

  // Restoring step: shift in next dividend bit, keep the subtraction if it did not borrow.
  assign rem_sh_s  = {div_rem_r, div_quo_r[XLEN-1]};
  assign diff_s    = rem_sh_s - {1'b0, div_dvs_r};
  assign q_bit_s   = ~diff_s[XLEN];
  assign rem_nx_s  = q_bit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_nx_s  = {div_quo_r[XLEN-2:0], q_bit_s};
  assign div_res_s = op_rem_r ? (neg_r_r ? (~rem_nx_s + {{(XLEN-1){1'b0}}, 1'b1}) : rem_nx_s)
                              : (neg_q_r ? (~quo_nx_s + {{(XLEN-1){1'b0}}, 1'b1}) : quo_nx_s);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; flush wins over everything including accept
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!req_valid) begin
            state_nx_s = ST_IDLE;
          end else if (is_div_s) begin
            state_nx_s = special_s ? ST_DONE : ST_DIV;
          end else begin
            state_nx_s = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          if (cnt_r == MUL_LAST) state_nx_s = ST_DONE;
          else                   state_nx_s = ST_MUL;
        end
        ST_DIV: begin
          if (cnt_r == DIV_LAST) state_nx_s = ST_DONE;
          else                   state_nx_s = ST_DIV;
        end
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, multiply pipeline, divider iteration, result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= 6'd0;
      op_rem_r     <= 1'b0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      div_quo_r    <= {XLEN{1'b0}};
      div_rem_r    <= {XLEN{1'b0}};
      div_dvs_r    <= {XLEN{1'b0}};
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {XLEN{1'b0}};
      for (int i = 0; i < PIPE_N; i++) mul_pipe_r[i] <= {XLEN{1'b0}};
    end else begin
      busy_r       <= (state_nx_s != ST_IDLE);
      resp_valid_r <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            cnt_r         <= 6'd0;
            op_rem_r      <= req_opcode[1];
            neg_q_r       <= op1_neg_s ^ op2_neg_s;
            neg_r_r       <= op1_neg_s;
            div_quo_r     <= op1_mag_s;
            div_rem_r     <= {XLEN{1'b0}};
            div_dvs_r     <= op2_mag_s;
            mul_pipe_r[0] <= mul_sel_s;
            if (state_nx_s == ST_DONE) begin
              resp_data_r <= is_div_s ? special_res_s : mul_sel_s;
            end
          end
        end
        ST_MUL: begin
          cnt_r <= cnt_r + 6'd1;
          for (int i = 1; i < PIPE_N; i++) mul_pipe_r[i] <= mul_pipe_r[i-1];
          if (state_nx_s == ST_DONE) resp_data_r <= mul_pipe_r[PIPE_N-1];
        end
        ST_DIV: begin
          cnt_r     <= cnt_r + 6'd1;
          div_quo_r <= quo_nx_s;
          div_rem_r <= rem_nx_s;
          if (state_nx_s == ST_DONE) resp_data_r <= div_res_s;
        end
        ST_DONE: begin
          cnt_r <= 6'd0;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_opcode;
  logic [31:0] req_op1, req_op2;
  logic        busy, resp_valid;
  logic [31:0] resp_data;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = 32'd0;

  ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2),
    .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (op)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      3'd7: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one request, hold it like a stalled EX stage, and check latency/result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit junk);
    logic [31:0] exp;
    int          lat, cyc;
    bit          seen;
    exp        = ref_result(op, a, b);
    lat        = ref_lat(op, a, b);
    req_valid  = 1'b1;
    req_opcode = op;
    req_op1    = a;
    req_op2    = b;
    if (resp_valid) begin
      @(posedge clk); #1;
      check("no_accept_in_done", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    if (junk) begin
      req_opcode = 3'($urandom);
      req_op1    = $urandom;
      req_op2    = $urandom;
    end
    seen = 1'b0;
    cyc  = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_c1", 64'(busy), 64'd1);
        if (lat > 1) check("hold_prev", 64'(resp_data), 64'(last_res));
      end
      if (resp_valid) begin
        seen = 1'b1;
        cyc  = c;
      end
    end
    req_valid = 1'b0;
    check($sformatf("latency_op%0d", op), 64'(cyc), 64'(lat));
    check($sformatf("data_op%0d_%h_%h", op, a, b), 64'(resp_data), 64'(exp));
    check("busy_at_resp", 64'(busy), 64'd1);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_opcode = 3'd0; req_op1 = 32'd0; req_op2 = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plan items 1-4
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("t1_value", 64'(resp_data), 64'h0000_0000_FFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("t3_div", 64'(resp_data), 64'h0000_0000_FFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("t3_rem", 64'(resp_data), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 1'b1);
    run_op(3'd7, 32'd100, 32'd7, 1'b1);
    run_op(3'd5, 32'd5, 32'd0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush has priority over accept
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_beats_accept", 64'(busy), 64'd0);

    // Plan item 5: flush during the 10th divide iteration
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd4; req_op1 = 32'd1000; req_op2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_no_resp", 64'(resp_valid), 64'd0);
    check("flush_data_kept", 64'(resp_data), 64'(last_res));
    run_op(3'd0, 32'd123, 32'd456, 1'b0);

    // Plan item 6: asynchronous reset mid-divide
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd5; req_op1 = 32'd999; req_op2 = 32'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_resp_data", 64'(resp_data), 64'd0);
    last_res = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 60; n++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
